// File: rtl/read_addr_arbiter.sv
// read_addr_arbiter: AR-side arbiter for the 3-master / 8-slave AXI interconnect.
// Grants one master AR request, decodes its address top nibble to a slave,
// drives the AR_arbiter route code and the AR valid/ready handshake, and holds
// the route until the last read beat of the burst is accepted by the master.
// Optional build macro AR_ROUND_ROBIN_EN: round-robin arbitration instead of
// fixed priority M0 > M1 > M2.
module read_addr_arbiter #(
  parameter logic [7:0] SLAVE_EN = 8'hFF,
  parameter int         ADDR_W   = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  input  logic              ARVALID_M2,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [ADDR_W-1:0] ARADDR_M2,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic              ARREADY_M2,
  output logic [7:0]        ARVALID_S,
  input  logic [7:0]        ARREADY_S,
  input  logic [7:0]        RVALID_S,
  input  logic [7:0]        RLAST_S,
  input  logic [2:0]        RREADY_M,
  output logic [5:0]        AR_arbiter,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [5:0] CODE_NONE = 6'h3F;
  localparam logic [3:0] SLV_MISS  = 4'hF;

  state_t      state, state_nxt;
  logic [5:0]  code_q, code_nxt;
  logic [2:0]  req;
  logic [1:0]  winner;
  logic [3:0]  nib;
  logic [3:0]  slave_dec;
  logic [1:0]  gnt;
  logic [2:0]  gnt_onehot;
  logic [2:0]  route_idx;
  logic        gnt_valid;
  logic        gnt_rready;
  logic        slv_ready;
  logic [2:0]  arready_m;
  logic        addr_unused;

  assign req = {ARVALID_M2, ARVALID_M1, ARVALID_M0};

  // Only the top nibble takes part in decode; the rest of the address is payload.
  assign addr_unused = ^{ARADDR_M0[ADDR_W-5:0], ARADDR_M1[ADDR_W-5:0], ARADDR_M2[ADDR_W-5:0]};

`ifdef AR_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  // Round-robin winner: scan offsets from the pointer, nearest requester wins.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] cand;
    winner = 2'd0;
    sum    = 3'd0;
    cand   = 2'd0;
    // Scan from the farthest offset down so the nearest requester is written last.
    for (int i = 2; i >= 0; i--) begin
      sum  = {1'b0, rr_ptr} + 3'(i);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (req[cand]) winner = cand;
    end
  end

  // Pointer moves past the winner on every grant.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      rr_ptr <= 2'd0;
    else if (state == IDLE && |req)
      rr_ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
  end
`else
  // Fixed priority winner: M0 > M1 > M2.
  always_comb begin
    if (req[0])      winner = 2'd0;
    else if (req[1]) winner = 2'd1;
    else             winner = 2'd2;
  end
`endif

  // Decode the winner's address top nibble; absent or out-of-range slaves miss.
  always_comb begin
    case (winner)
      2'd0:    nib = ARADDR_M0[ADDR_W-1 -: 4];
      2'd1:    nib = ARADDR_M1[ADDR_W-1 -: 4];
      default: nib = ARADDR_M2[ADDR_W-1 -: 4];
    endcase
    slave_dec = (!nib[3] && SLAVE_EN[nib[2:0]]) ? nib : SLV_MISS;
  end

  // Decode the registered route: granted master one-hot and routed slave index.
  always_comb begin
    gnt = code_q[5:4];
    case (gnt)
      2'd0:    gnt_onehot = 3'b001;
      2'd1:    gnt_onehot = 3'b010;
      2'd2:    gnt_onehot = 3'b100;
      default: gnt_onehot = 3'b000;
    endcase
    // A miss is served by S0, the default slave that answers DECERR.
    route_idx  = (code_q[3:0] == SLV_MISS) ? 3'd0 : code_q[2:0];
    gnt_valid  = |(req & gnt_onehot);
    gnt_rready = |(RREADY_M & gnt_onehot);
    slv_ready  = ARREADY_S[route_idx];
  end

  // Next-state, next route code and AR handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt = state;
    code_nxt  = code_q;
    ARVALID_S = 8'h00;
    arready_m = 3'b000;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ADDR;
          code_nxt  = {winner, slave_dec};
        end
      end
      ADDR: begin
        ARVALID_S[route_idx] = gnt_valid;
        arready_m            = gnt_onehot & {3{slv_ready}};
        // A master dropping ARVALID here simply leaves us waiting in ADDR.
        if (gnt_valid && slv_ready) state_nxt = DATA;
      end
      DATA: begin
        if (RVALID_S[route_idx] && RLAST_S[route_idx] && gnt_rready) begin
          state_nxt = IDLE;
          code_nxt  = CODE_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = CODE_NONE;
      end
    endcase
  end

  // State and route code registers; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!ARESETn) begin
      state  <= IDLE;
      code_q <= CODE_NONE;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
    end
  end

  assign {ARREADY_M2, ARREADY_M1, ARREADY_M0} = arready_m;
  assign AR_arbiter = code_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_read_addr_arbiter.sv
// Testbench for read_addr_arbiter: cycle-by-cycle vector table for single
// reads, decode misses and contention, plus hand-written sequences for reset,
// backpressure, mid-burst reset and repeated contention by two masters.
module tb_read_addr_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic        ARVALID_M0, ARVALID_M1, ARVALID_M2;
  logic [31:0] ARADDR_M0, ARADDR_M1, ARADDR_M2;
  logic        ARREADY_M0, ARREADY_M1, ARREADY_M2;
  logic [7:0]  ARVALID_S, ARREADY_S, RVALID_S, RLAST_S;
  logic [2:0]  RREADY_M;
  logic [5:0]  AR_arbiter;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  read_addr_arbiter #(.SLAVE_EN(8'h7F), .ADDR_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1), .ARVALID_M2(ARVALID_M2),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1), .ARADDR_M2(ARADDR_M2),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1), .ARREADY_M2(ARREADY_M2),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RLAST_S(RLAST_S), .RREADY_M(RREADY_M),
    .AR_arbiter(AR_arbiter), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] arv;
    logic [3:0] n0, n1, n2;
    logic [7:0] ars, rv, rl;
    logic [2:0] rr;
    logic [5:0] e_code;
    logic [7:0] e_avs;
    logic [2:0] e_arm;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [5:0] code, input logic [7:0] avs,
                           input logic [2:0] arm, input logic bsy);
    check({name, ".code"}, 32'(AR_arbiter), 32'(code));
    check({name, ".arvalid_s"}, 32'(ARVALID_S), 32'(avs));
    check({name, ".arready_m"}, 32'({ARREADY_M2, ARREADY_M1, ARREADY_M0}), 32'(arm));
    check({name, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic drive(input logic [2:0] arv, input logic [3:0] n0, input logic [3:0] n1,
                       input logic [3:0] n2, input logic [7:0] ars, input logic [7:0] rv,
                       input logic [7:0] rl, input logic [2:0] rr);
    {ARVALID_M2, ARVALID_M1, ARVALID_M0} = arv;
    ARADDR_M0 = {n0, 28'h000_0040};
    ARADDR_M1 = {n1, 28'h000_0040};
    ARADDR_M2 = {n2, 28'h000_0040};
    ARREADY_S = ars;
    RVALID_S  = rv;
    RLAST_S   = rl;
    RREADY_M  = rr;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic add(input string name, input logic [2:0] arv, input logic [3:0] n0,
                     input logic [3:0] n1, input logic [3:0] n2, input logic [7:0] ars,
                     input logic [7:0] rv, input logic [7:0] rl, input logic [2:0] rr,
                     input logic [5:0] e_code, input logic [7:0] e_avs,
                     input logic [2:0] e_arm, input logic e_busy);
    vec_t v;
    v.name = name; v.arv = arv; v.n0 = n0; v.n1 = n1; v.n2 = n2;
    v.ars = ars; v.rv = rv; v.rl = rl; v.rr = rr;
    v.e_code = e_code; v.e_avs = e_avs; v.e_arm = e_arm; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  logic [5:0] exp_codes [4];

  initial begin
    // Single read: M1 -> S2 (32'h2000_0040), 4-beat burst.
    add("a_idle",   3'b000, 4'h0, 4'h2, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("a_req",    3'b010, 4'h0, 4'h2, 4'h0, 8'h04, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("a_addr",   3'b010, 4'h0, 4'h2, 4'h0, 8'h04, 8'h00, 8'h00, 3'b000, 6'h12, 8'h04, 3'b010, 1'b1);
    add("a_beat1",  3'b000, 4'h0, 4'h2, 4'h0, 8'h04, 8'h04, 8'h00, 3'b010, 6'h12, 8'h00, 3'b000, 1'b1);
    add("a_beat2",  3'b000, 4'h0, 4'h2, 4'h0, 8'h04, 8'h04, 8'h00, 3'b010, 6'h12, 8'h00, 3'b000, 1'b1);
    add("a_beat3",  3'b000, 4'h0, 4'h2, 4'h0, 8'h04, 8'h04, 8'h00, 3'b010, 6'h12, 8'h00, 3'b000, 1'b1);
    add("a_last",   3'b000, 4'h0, 4'h2, 4'h0, 8'h04, 8'h04, 8'h04, 3'b010, 6'h12, 8'h00, 3'b000, 1'b1);
    add("a_done",   3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    // Decode miss: S7 disabled by SLAVE_EN=8'h7F, routed to default slave S0.
    add("b_req",    3'b001, 4'h7, 4'h0, 4'h0, 8'h01, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("b_addr",   3'b001, 4'h7, 4'h0, 4'h0, 8'h01, 8'h00, 8'h00, 3'b000, 6'h0F, 8'h01, 3'b001, 1'b1);
    add("b_s7last", 3'b000, 4'h7, 4'h0, 4'h0, 8'h00, 8'h80, 8'h80, 3'b001, 6'h0F, 8'h00, 3'b000, 1'b1);
    add("b_last",   3'b000, 4'h7, 4'h0, 4'h0, 8'h00, 8'h01, 8'h01, 3'b001, 6'h0F, 8'h00, 3'b000, 1'b1);
    add("b_done",   3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    // Decode miss: nibble 9 is beyond the eight slaves.
    add("b2_req",   3'b100, 4'h0, 4'h0, 4'h9, 8'h01, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("b2_addr",  3'b100, 4'h0, 4'h0, 4'h9, 8'h01, 8'h00, 8'h00, 3'b000, 6'h2F, 8'h01, 3'b100, 1'b1);
    add("b2_wrrdy", 3'b000, 4'h0, 4'h0, 4'h9, 8'h00, 8'h01, 8'h01, 3'b001, 6'h2F, 8'h00, 3'b000, 1'b1);
    add("b2_last",  3'b000, 4'h0, 4'h0, 4'h9, 8'h00, 8'h01, 8'h01, 3'b100, 6'h2F, 8'h00, 3'b000, 1'b1);
    add("b2_done",  3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    // Contention: all three masters to S3, served M0, M1, M2.
    add("c0", 3'b111, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("c1", 3'b111, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h03, 8'h08, 3'b001, 1'b1);
    add("c2", 3'b110, 4'h3, 4'h3, 4'h3, 8'h08, 8'h08, 8'h08, 3'b001, 6'h03, 8'h00, 3'b000, 1'b1);
    add("c3", 3'b110, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("c4", 3'b110, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h13, 8'h08, 3'b010, 1'b1);
    add("c5", 3'b100, 4'h3, 4'h3, 4'h3, 8'h08, 8'h08, 8'h08, 3'b010, 6'h13, 8'h00, 3'b000, 1'b1);
    add("c6", 3'b100, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);
    add("c7", 3'b100, 4'h3, 4'h3, 4'h3, 8'h08, 8'h00, 8'h00, 3'b000, 6'h23, 8'h08, 3'b100, 1'b1);
    add("c8", 3'b000, 4'h3, 4'h3, 4'h3, 8'h08, 8'h08, 8'h08, 3'b100, 6'h23, 8'h00, 3'b000, 1'b1);
    add("c9", 3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000, 6'h3F, 8'h00, 3'b000, 1'b0);

    // Reset and idle.
    ARESETn = 1'b0;
    drive(3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000);
    repeat (3) tick();
    check_all("reset", 6'h3F, 8'h00, 3'b000, 1'b0);
    #2 ARESETn = 1'b1;
    repeat (3) tick();
    check_all("idle_after_reset", 6'h3F, 8'h00, 3'b000, 1'b0);

    // Vector table: each row drives inputs, checks outputs, then clocks once.
    foreach (vecs[i]) begin
      drive(vecs[i].arv, vecs[i].n0, vecs[i].n1, vecs[i].n2,
            vecs[i].ars, vecs[i].rv, vecs[i].rl, vecs[i].rr);
      #2;
      check_all(vecs[i].name, vecs[i].e_code, vecs[i].e_avs, vecs[i].e_arm, vecs[i].e_busy);
      tick();
    end

    // Backpressure: M2 -> S5 with ARREADY_S low for five cycles.
    drive(3'b100, 4'h0, 4'h0, 4'h5, 8'h00, 8'h00, 8'h00, 3'b000);
    tick();
    for (int i = 0; i < 5; i++) begin
      #2 check_all($sformatf("bp_wait%0d", i), 6'h25, 8'h20, 3'b000, 1'b1);
      tick();
    end
    // Master drops ARVALID in ADDR: stays in ADDR, nothing forwarded.
    drive(3'b000, 4'h0, 4'h0, 4'h5, 8'h00, 8'h00, 8'h00, 3'b000);
    #2 check_all("bp_drop", 6'h25, 8'h00, 3'b000, 1'b1);
    tick();
    #2 check_all("bp_drop_hold", 6'h25, 8'h00, 3'b000, 1'b1);
    drive(3'b100, 4'h0, 4'h0, 4'h5, 8'h20, 8'h00, 8'h00, 3'b000);
    #2 check_all("bp_accept", 6'h25, 8'h20, 3'b100, 1'b1);
    tick();
    // RLAST with RREADY low: stays in DATA.
    drive(3'b000, 4'h0, 4'h0, 4'h5, 8'h00, 8'h20, 8'h20, 3'b000);
    tick();
    #2 check_all("rlast_no_rready", 6'h25, 8'h00, 3'b000, 1'b1);
    // Reset pulse in DATA: values return without waiting for a clock edge.
    ARESETn = 1'b0;
    #1 check_all("mid_burst_reset", 6'h3F, 8'h00, 3'b000, 1'b0);
    drive(3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000);
    tick();
    #2 ARESETn = 1'b1;
    tick();
    #2 check_all("post_reset_idle", 6'h3F, 8'h00, 3'b000, 1'b0);

    // M0 and M1 both held valid to S3 over four bursts.
`ifdef AR_ROUND_ROBIN_EN
    exp_codes[0] = 6'h03; exp_codes[1] = 6'h13; exp_codes[2] = 6'h03; exp_codes[3] = 6'h13;
`else
    exp_codes[0] = 6'h03; exp_codes[1] = 6'h03; exp_codes[2] = 6'h03; exp_codes[3] = 6'h03;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(3'b011, 4'h3, 4'h3, 4'h0, 8'h08, 8'h00, 8'h00, 3'b000);
      tick();
      #2 check($sformatf("hold2_grant%0d", i), 32'(AR_arbiter), 32'(exp_codes[i]));
      tick();
      drive(3'b011, 4'h3, 4'h3, 4'h0, 8'h08, 8'h08, 8'h08, 3'b111);
      tick();
    end
    drive(3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000);
    #2 check_all("final_idle", 6'h3F, 8'h00, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
